// File: rtl/spi_sram_bridge.sv
// ---------------------------------------------------------------------------
// spi_sram_bridge
//
// Turns the address/data words captured by the dual-chip-select SPI slave
// into single request/acknowledge transactions on the internal SRAM-like bus,
// and hands read data back to the slave's transmit input.
// The address word MSB selects write (1) or read (0). The remaining bits form
// the bus address.
//
// Optional feature:
//   SPI_BRIDGE_TIMEOUT_EN - when defined, a transaction that sees no bus_ack
//                           within timeout_cycles is abandoned. err is set and
//                           a read returns all-ones. When undefined, the
//                           bridge waits for bus_ack indefinitely and err is 0.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   spi_cs_addr       raw address chip select pin (active low)
//   spi_addr          slave Addr word (MSB = R/W)
//   spi_wdata         slave Dout word
//   spi_data_begin    slave Data_begin pulse (unused: spi_rdata is pre-loaded)
//   spi_data_end      slave Data_end pulse
//   spi_rdata         read data to slave Din
//   bus_req/bus_we    request and direction, held until the ack cycle
//   bus_addr          bus address, width_addr-1 bits
//   bus_wdata         write data
//   bus_ack           1-cycle completion pulse
//   bus_rdata         read data, valid with bus_ack
//   busy              a transaction is outstanding
//   err, err_clr      sticky timeout flag and its clear
// ---------------------------------------------------------------------------
module spi_sram_bridge #(
  parameter int width_addr     = 8,
  parameter int width_data     = 16,
  parameter int timeout_cycles = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_cs_addr,
  input  logic [width_addr-1:0] spi_addr,
  input  logic [width_data-1:0] spi_wdata,
  input  logic                  spi_data_begin,
  input  logic                  spi_data_end,
  output logic [width_data-1:0] spi_rdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [width_addr-2:0] bus_addr,
  output logic [width_data-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [width_data-1:0] bus_rdata,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int addr_bits = width_addr - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  logic [1:0]            state;

  logic                  cs_meta;
  logic                  cs_sync;
  logic                  cs_prev;
  logic                  addr_end;

  logic                  wr_armed;
  logic [addr_bits-1:0]  armed_addr;

  logic                  rd_pend;
  logic                  wr_pend;
  logic [addr_bits-1:0]  rd_slot_addr;
  logic [addr_bits-1:0]  wr_slot_addr;
  logic [width_data-1:0] wr_slot_data;

  logic                  new_rd;
  logic                  new_wr;
  logic                  rd_avail;
  logic                  wr_avail;
  logic [addr_bits-1:0]  rd_addr_n;
  logic [addr_bits-1:0]  wr_addr_n;
  logic [width_data-1:0] wr_data_n;

  logic                  timeout;
  logic                  done;
  logic                  unused_inputs;

  // The chip select idles high, so the synchroniser resets to 1. Otherwise a
  // phantom addr-phase end would appear just after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      cs_prev <= 1'b1;
    end else begin
      cs_meta <= spi_cs_addr;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
    end
  end

  assign addr_end = cs_sync & ~cs_prev;

  // A data_end only means "write" if an earlier address phase armed one.
  // It is judged against the registered wr_armed, so an address phase ending
  // in the same cycle cannot affect it.
  assign new_wr = spi_data_end & wr_armed;
  assign new_rd = addr_end & ~spi_addr[width_addr-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_armed   <= 1'b0;
      armed_addr <= '0;
    end else if (addr_end) begin
      wr_armed <= spi_addr[width_addr-1];
      if (spi_addr[width_addr-1]) begin
        armed_addr <= spi_addr[addr_bits-1:0];
      end
    end else if (new_wr) begin
      wr_armed <= 1'b0;
    end
  end

  // Slot contents after this cycle's arrivals. A newer request of the same
  // kind replaces the older one. Arrivals seen while IDLE are launched
  // straight from these values, which keeps the write latency at one cycle.
  always_comb begin
    wr_avail  = wr_pend;
    wr_addr_n = wr_slot_addr;
    wr_data_n = wr_slot_data;
    rd_avail  = rd_pend;
    rd_addr_n = rd_slot_addr;
    if (new_wr) begin
      wr_avail  = 1'b1;
      wr_addr_n = armed_addr;
      wr_data_n = spi_wdata;
    end
    if (new_rd) begin
      rd_avail  = 1'b1;
      rd_addr_n = spi_addr[addr_bits-1:0];
    end
  end

`ifdef SPI_BRIDGE_TIMEOUT_EN
  localparam int cnt_bits = $clog2(timeout_cycles + 1);

  logic [cnt_bits-1:0] to_cnt;

  // The counter sits at 0 in IDLE, so it starts from 0 on every RD/WR entry.
  // Timing out on the count value timeout_cycles-1 keeps bus_req high for
  // exactly timeout_cycles cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE) begin
      to_cnt <= '0;
    end else if (!bus_ack) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state != ST_IDLE) && !bus_ack &&
                   (to_cnt == cnt_bits'(timeout_cycles - 1));

  // A timeout in the same cycle as err_clr leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  assign unused_inputs = spi_data_begin;
`else
  assign timeout       = 1'b0;
  assign err           = 1'b0;
  assign unused_inputs = spi_data_begin ^ err_clr ^ (timeout_cycles == 0);
`endif

  assign done = (state != ST_IDLE) && (bus_ack || timeout);

  // Main transaction FSM. The bus_addr and bus_wdata registers are loaded
  // only when a transaction launches, so they stay constant until the ack.
  // Pending flags are refreshed every cycle from the slot view above. IDLE
  // clears the flag of whichever kind it launches. Write wins over read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      spi_rdata    <= '0;
      rd_pend      <= 1'b0;
      wr_pend      <= 1'b0;
      rd_slot_addr <= '0;
      wr_slot_addr <= '0;
      wr_slot_data <= '0;
    end else begin
      rd_slot_addr <= rd_addr_n;
      wr_slot_addr <= wr_addr_n;
      wr_slot_data <= wr_data_n;
      rd_pend      <= rd_avail;
      wr_pend      <= wr_avail;
      case (state)
        ST_IDLE: begin
          if (wr_avail) begin
            state     <= ST_WR;
            bus_addr  <= wr_addr_n;
            bus_wdata <= wr_data_n;
            wr_pend   <= 1'b0;
          end else if (rd_avail) begin
            state    <= ST_RD;
            bus_addr <= rd_addr_n;
            rd_pend  <= 1'b0;
          end else if (addr_end) begin
            bus_addr <= spi_addr[addr_bits-1:0];
          end
        end
        ST_RD, ST_WR: begin
          if (done) begin
            state <= ST_IDLE;
            if (state == ST_RD) begin
              spi_rdata <= bus_ack ? bus_rdata : '1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_req = (state == ST_RD) || (state == ST_WR);
  assign bus_we  = (state == ST_WR);
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_sram_bridge.sv
// ---------------------------------------------------------------------------
// tb_spi_sram_bridge
//
// Drives the slave-side signals of spi_sram_bridge directly. A small SRAM
// device model answers the bus. Expected results come from a separate
// memory model of what the SPI master believes it has written. Timeout
// sequences run when SPI_BRIDGE_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_spi_sram_bridge;

  localparam int width_addr     = 8;
  localparam int width_data     = 16;
  localparam int timeout_cycles = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_cs_addr;
  logic [7:0]  spi_addr;
  logic [15:0] spi_wdata;
  logic        spi_data_begin;
  logic        spi_data_end;
  logic [15:0] spi_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [6:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic        busy;
  logic        err;
  logic        err_clr;

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] wdata;
  } txn_t;

  typedef struct {
    logic [7:0]  addr_word;
    logic [15:0] wdata;
    int          ack_delay;
    logic        exp_we;
    logic [6:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          ack_delay = 0;
  logic        ack_off = 1'b0;
  int          age = 0;
  int          hold_viol = 0;
  logic        req_prev = 1'b0;
  txn_t        start_t;
  txn_t        mon_t;
  txn_t        got;
  txn_t        done_q[$];
  logic [15:0] sram [0:127];
  logic [15:0] model_mem [0:127];
  vec_t        vecs [0:8];
  vec_t        rv;
  logic        r_wr;
  logic [6:0]  r_addr;
  int          hi_cnt;

  spi_sram_bridge #(
    .width_addr(width_addr),
    .width_data(width_data),
    .timeout_cycles(timeout_cycles)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_cs_addr(spi_cs_addr),
    .spi_addr(spi_addr),
    .spi_wdata(spi_wdata),
    .spi_data_begin(spi_data_begin),
    .spi_data_end(spi_data_end),
    .spi_rdata(spi_rdata),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack(bus_ack),
    .bus_rdata(bus_rdata),
    .busy(busy),
    .err(err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // SRAM device: acks after ack_delay request cycles and returns its content.
  // Outside the ack cycle it drives random garbage on bus_rdata.
  initial begin
    bus_ack   = 1'b0;
    bus_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus_ack = 1'b0;
        age     = 0;
      end else if (bus_ack) begin
        bus_ack   = 1'b0;
        age       = 0;
        bus_rdata = 16'($urandom);
      end else if (bus_req && !ack_off) begin
        if (age >= ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = sram[bus_addr];
        end else begin
          age++;
          bus_rdata = 16'($urandom);
        end
      end else begin
        age       = 0;
        bus_rdata = 16'($urandom);
      end
    end
  end

  // Bus monitor: logs completed transactions, applies writes to the SRAM,
  // and counts any change of request fields while a request is open.
  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
    end else begin
      if (bus_req && !req_prev) begin
        start_t = '{we: bus_we, addr: bus_addr, wdata: bus_wdata};
      end else if (bus_req) begin
        if (bus_we !== start_t.we || bus_addr !== start_t.addr ||
            bus_wdata !== start_t.wdata) begin
          hold_viol++;
        end
      end
      if (bus_req && bus_ack) begin
        mon_t = '{we: bus_we, addr: bus_addr, wdata: bus_wdata};
        done_q.push_back(mon_t);
        if (bus_we) begin
          sram[bus_addr] = bus_wdata;
        end
      end
      req_prev = bus_req;
    end
  end

  task automatic check_value(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_busy(input logic level, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== level && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_value(name, 32'(busy), 32'(level));
  endtask

  task automatic spi_addr_phase(input logic [7:0] aw);
    @(posedge clk);
    #1;
    spi_cs_addr = 1'b0;
    spi_addr    = aw;
    repeat (3) @(posedge clk);
    #1;
    spi_cs_addr = 1'b1;
  endtask

  task automatic spi_data_phase(input logic [15:0] d);
    @(posedge clk);
    #1;
    spi_data_begin = 1'b1;
    @(posedge clk);
    #1;
    spi_data_begin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    spi_wdata    = d;
    spi_data_end = 1'b1;
    @(posedge clk);
    #1;
    spi_data_end = 1'b0;
  endtask

  // One complete SPI transfer as the master would issue it. A read is
  // followed by its (ignored) data phase, and the bench waits long enough
  // for any spurious write to show up.
  task automatic apply_stimulus(input vec_t v);
    ack_delay = v.ack_delay;
    spi_addr_phase(v.addr_word);
    if (v.addr_word[7]) begin
      repeat (4) @(posedge clk);
      spi_data_phase(v.wdata);
    end
    wait_busy(1'b1, "busy_rise");
    wait_busy(1'b0, "busy_fall");
    if (!v.addr_word[7]) begin
      spi_data_phase(v.wdata);
      repeat (3) @(posedge clk);
      wait_busy(1'b0, "idle_after_data");
    end
  endtask

  task automatic check_output(input vec_t v);
    check_value("txn_count", 32'(done_q.size()), 1);
    if (done_q.size() != 0) begin
      got = done_q.pop_front();
      check_value("bus_we", 32'(got.we), 32'(v.exp_we));
      check_value("bus_addr", 32'(got.addr), 32'(v.exp_addr));
      if (v.exp_we) begin
        check_value("bus_wdata", 32'(got.wdata), 32'(v.exp_data));
      end else begin
        check_value("spi_rdata", 32'(spi_rdata), 32'(v.exp_data));
      end
    end
    done_q.delete();
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    while (!bus_ack && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_value(name, 32'(bus_ack), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    spi_cs_addr    = 1'b1;
    spi_addr       = 8'h00;
    spi_wdata      = 16'h0000;
    spi_data_begin = 1'b0;
    spi_data_end   = 1'b0;
    err_clr        = 1'b0;
    for (int i = 0; i < 128; i++) begin
      sram[i]      = 16'hA5BE + 16'(i);
      model_mem[i] = 16'hA5BE + 16'(i);
    end

    // Expected outcomes of each table transfer, following earlier writes.
    vecs[0] = '{8'h05, 16'hFFFF, 0, 1'b0, 7'h05, 16'h1234};
    vecs[1] = '{8'hFF, 16'hFFFF, 1, 1'b1, 7'h7F, 16'hFFFF};
    vecs[2] = '{8'h7F, 16'h0F0F, 5, 1'b0, 7'h7F, 16'hFFFF};
    vecs[3] = '{8'h00, 16'hFFFF, 1, 1'b0, 7'h00, 16'hA5BE};
    vecs[4] = '{8'h80, 16'h0000, 0, 1'b1, 7'h00, 16'h0000};
    vecs[5] = '{8'h00, 16'h1111, 4, 1'b0, 7'h00, 16'h0000};
    vecs[6] = '{8'h10, 16'hFFFF, 2, 1'b0, 7'h10, 16'hA5CE};
    vecs[7] = '{8'h8A, 16'hC0DE, 6, 1'b1, 7'h0A, 16'hC0DE};
    vecs[8] = '{8'h0A, 16'hFFFF, 3, 1'b0, 7'h0A, 16'hC0DE};

    @(negedge clk);
    check_value("rst_spi_rdata", 32'(spi_rdata), 0);
    check_value("rst_bus_addr", 32'(bus_addr), 0);
    check_value("rst_bus_wdata", 32'(bus_wdata), 0);
    check_value("rst_bus_req", 32'(bus_req), 0);
    check_value("rst_bus_we", 32'(bus_we), 0);
    check_value("rst_busy", 32'(busy), 0);
    check_value("rst_err", 32'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_value("idle_after_rst", 32'(busy), 0);

    // Read 0x05: 3-cycle request latency from the raw chip select rise.
    ack_delay = 2;
    @(posedge clk);
    #1;
    spi_cs_addr = 1'b0;
    spi_addr    = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    spi_cs_addr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("rd_lat_early", 32'(bus_req), 0);
    @(negedge clk);
    check_value("rd_lat_req", 32'(bus_req), 1);
    check_value("rd_lat_we", 32'(bus_we), 0);
    check_value("rd_lat_addr", 32'(bus_addr), 32'h05);
    wait_ack("rd_ack_seen");
    check_value("rd_busy_at_ack", 32'(busy), 1);
    check_value("rd_rdata_at_ack", 32'(spi_rdata), 0);
    @(negedge clk);
    check_value("rd_busy_after", 32'(busy), 0);
    check_value("rd_req_after", 32'(bus_req), 0);
    check_value("rd_rdata_after", 32'(spi_rdata), 32'hA5C3);

    // A data phase after a read address must not create a write.
    spi_data_phase(16'hFFFF);
    repeat (8) @(negedge clk);
    check_value("no_write_count", 32'(done_q.size()), 1);
    check_value("no_write_busy", 32'(busy), 0);
    done_q.delete();

    // Write 0x85/0x1234: request one cycle after data_end.
    ack_delay = 3;
    spi_addr_phase(8'h85);
    repeat (4) @(posedge clk);
    @(posedge clk);
    #1;
    spi_wdata    = 16'h1234;
    spi_data_end = 1'b1;
    @(negedge clk);
    check_value("wr_lat_early", 32'(bus_req), 0);
    @(posedge clk);
    #1;
    spi_data_end = 1'b0;
    @(negedge clk);
    check_value("wr_lat_req", 32'(bus_req), 1);
    check_value("wr_lat_we", 32'(bus_we), 1);
    check_value("wr_lat_addr", 32'(bus_addr), 32'h05);
    check_value("wr_lat_wdata", 32'(bus_wdata), 32'h1234);
    wait_ack("wr_ack_seen");
    check_value("wr_busy_at_ack", 32'(busy), 1);
    @(negedge clk);
    check_value("wr_busy_after", 32'(busy), 0);
    model_mem[5] = 16'h1234;
    check_value("wr_count", 32'(done_q.size()), 1);
    done_q.delete();

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i]);
      if (vecs[i].addr_word[7]) begin
        model_mem[vecs[i].addr_word[6:0]] = vecs[i].wdata;
      end
    end

    // Collision: a read address ends while a write waits for its ack.
    ack_off   = 1'b1;
    ack_delay = 2;
    spi_addr_phase(8'h82);
    repeat (4) @(posedge clk);
    spi_data_phase(16'hBEEF);
    spi_addr_phase(8'h03);
    repeat (6) @(negedge clk);
    check_value("col_hold_we", 32'(bus_we), 1);
    check_value("col_hold_addr", 32'(bus_addr), 32'h02);
    check_value("col_hold_busy", 32'(busy), 1);
    ack_off = 1'b0;
    wait_ack("col_wr_ack");
    @(negedge clk);
    check_value("col_idle_gap", 32'(bus_req), 0);
    @(negedge clk);
    check_value("col_rd_req", 32'(bus_req), 1);
    check_value("col_rd_we", 32'(bus_we), 0);
    check_value("col_rd_addr", 32'(bus_addr), 32'h03);
    wait_busy(1'b0, "col_done");
    model_mem[2] = 16'hBEEF;
    check_value("col_count", 32'(done_q.size()), 2);
    if (done_q.size() == 2) begin
      got = done_q.pop_front();
      check_value("col_first_we", 32'(got.we), 1);
      check_value("col_first_addr", 32'(got.addr), 32'h02);
      check_value("col_first_wdata", 32'(got.wdata), 32'hBEEF);
      got = done_q.pop_front();
      check_value("col_second_we", 32'(got.we), 0);
      check_value("col_second_addr", 32'(got.addr), 32'h03);
    end
    check_value("col_rdata", 32'(spi_rdata), 32'(model_mem[3]));
    done_q.delete();

`ifdef SPI_BRIDGE_TIMEOUT_EN
    // Timeout: no ack for a read of 0x10.
    ack_off = 1'b1;
    spi_addr_phase(8'h10);
    wait_busy(1'b1, "to_busy_rise");
    hi_cnt = 0;
    while (bus_req && hi_cnt < 100) begin
      hi_cnt++;
      @(negedge clk);
    end
    check_value("to_req_cycles", 32'(hi_cnt), 16);
    check_value("to_err", 32'(err), 1);
    check_value("to_rdata", 32'(spi_rdata), 32'hFFFF);
    check_value("to_no_ack", 32'(done_q.size()), 0);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(negedge clk);
    check_value("to_err_held", 32'(err), 1);
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check_value("to_err_clr", 32'(err), 0);
    ack_off = 1'b0;
    done_q.delete();
`endif

    // Random transfers against the master-side memory model.
    for (int n = 0; n < 40; n++) begin
      r_wr         = 1'($urandom_range(0, 1));
      r_addr       = 7'($urandom_range(0, 15));
      rv.addr_word = {r_wr, r_addr};
      rv.wdata     = 16'($urandom);
      rv.ack_delay = int'($urandom_range(0, 6));
      rv.exp_we    = r_wr;
      rv.exp_addr  = r_addr;
      rv.exp_data  = r_wr ? rv.wdata : model_mem[r_addr];
      if (r_wr) begin
        model_mem[r_addr] = rv.wdata;
      end
      apply_stimulus(rv);
      check_output(rv);
    end

    // Reset while a write is stalled on the bus.
    ack_off = 1'b1;
    spi_addr_phase(8'h81);
    repeat (4) @(posedge clk);
    spi_data_phase(16'h5555);
    @(negedge clk);
    check_value("rstwr_req_before", 32'(bus_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("rstwr_req", 32'(bus_req), 0);
    check_value("rstwr_we", 32'(bus_we), 0);
    check_value("rstwr_busy", 32'(busy), 0);
    check_value("rstwr_addr", 32'(bus_addr), 0);
    check_value("rstwr_wdata", 32'(bus_wdata), 0);
    check_value("rstwr_rdata", 32'(spi_rdata), 0);
    check_value("rstwr_err", 32'(err), 0);
    ack_off = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_value("rstwr_no_ack", 32'(done_q.size()), 0);
    done_q.delete();
    repeat (3) @(negedge clk);
    rv = '{8'h05, 16'hFFFF, 1, 1'b0, 7'h05, model_mem[5]};
    apply_stimulus(rv);
    check_output(rv);

    check_value("bus_hold", 32'(hold_viol), 0);
    check_value("final_err", 32'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
